usr_feeder: RTL and testbench
=============================

# usr_feeder

Serialising front-end for the universal shift register stage (`usr`). It accepts a parallel word over a valid/ready handshake, then drives `usr`'s `cntrl`, `right_in` and `left_in` for exactly WIDTH clocks so that `usr.q` holds the word. It pulses `done` during the single cycle in which `q` equals the word. It sits directly upstream of `usr`, and its serial outputs connect one-to-one to `usr` inputs.

## Interface
- WIDTH, 4: word width; must equal the `usr` `q` width; minimum 2.
- clk  in  1  rising-edge clock, shared with `usr`.
- clr  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word available.
- in_ready  out  1  feeder can accept a word.
- in_data  in  WIDTH  word to load into `usr`.
- in_dir  in  1  0 = load via right shift, 1 = load via left shift; sampled with the word.
- cntrl  out  1  `usr` mode: 0 = right shift `q <= {right_in, q[W-1:1]}`, 1 = left shift `q <= {q[W-2:0], left_in}`.
- right_in  out  1  serial bit for right-shift mode.
- left_in  out  1  serial bit for left-shift mode.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; `usr.q` == accepted word during this cycle.
- word_cnt  out  8  count of completed words, wraps.

## Operation
- All outputs are registered. No combinational path runs from inputs to outputs.
- Reset values, asserted while clr=0:
  - state IDLE
  - in_ready=1
  - cntrl=0
  - right_in=0, left_in=0
  - busy=0, done=0
  - word_cnt=0
  - shadow register=0, bit counter=0
- FSM states IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on in_valid & in_ready.
  - SHIFT -> DONE after WIDTH bits have been driven.
  - DONE -> IDLE unconditionally.
- On accept:
  - in_data is latched into the shadow register and in_dir into cntrl.
  - in_ready drops to 0.
  - The bit counter clears.
- Bit order:
  - dir=0: LSB first on right_in, with left_in held 0.
  - dir=1: MSB first on left_in, with right_in held 0.
- The unused serial line is always 0. In IDLE and DONE, both serial lines are 0.
- cntrl holds its value after DONE until the next accept. Between words, `usr` keeps shifting zeros in the last direction.
- word_cnt increments by 1 on entry to DONE and wraps 255 -> 0.
- in_data and in_dir changes while busy are ignored, because the shadow register is used.
- in_valid while in_ready=0 is ignored. The word is not queued, so upstream must hold in_valid.

## Timing
- Edge E0 (accept): state -> SHIFT, busy=1, cntrl=in_dir, serial output = bit 0 of the send order.
- Edge Ek, k=1..WIDTH-1: `usr` captures bit k-1, and the feeder presents bit k.
- Edge E(WIDTH):
  - `usr` captures the last bit.
  - state -> DONE, done=1, serial outputs -> 0, word_cnt increments.
- Edge E(WIDTH+1):
  - state -> IDLE, done=0, busy=0, in_ready=1.
  - `usr` shifts in a 0, so q no longer holds the word.
- Earliest next accept is E(WIDTH+2). Throughput is 1 word per WIDTH+2 clocks.
- Accept-to-done latency is WIDTH clocks.
- Reset mid-word: clr low immediately forces reset values asynchronously. The partial word is discarded, and no done pulse is produced. After release, operation resumes from IDLE on the first rising edge with clr=1.
- in_valid high during the cycle clr deasserts: the word may be accepted on the first edge after release.

## Test plan
- Reset: hold clr=0 for 2 clocks with in_valid=1.
  - Required: in_ready=1, busy=0, done=0, cntrl=0, right_in=left_in=0, word_cnt=0, and no accept.
- Right load: send in_data=4'b1011, dir=0, with a `usr` model attached.
  - Required: right_in sequence 1,1,0,1 on E0..E3; done high in the cycle after E4; `usr` q=1011 that cycle; word_cnt=1.
- Left load: send in_data=4'b1000, dir=1.
  - Required: left_in sequence 1,0,0,0; right_in=0 throughout; cntrl=1; `usr` q=1000 during done; cntrl still 1 afterwards.
- Back-to-back: hold in_valid=1 with words 0x3 then 0xC.
  - Required: accepts exactly 6 clocks apart; two done pulses; in_data change during SHIFT has no effect; word_cnt=2.
- Abort: pull clr low for 1 clock after 2 bits have shifted.
  - Required: immediate reset values; no done pulse; a new word 0x5 then completes normally with word_cnt=1.
- Wrap: complete 256 words.
  - Required: word_cnt reads 255 and then 0.

Source files
------------

// File: rtl/usr_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usr_feeder: serialises a handshaked parallel word into usr's     |
// | cntrl/right_in/left_in so that usr.q holds the word on done.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module usr_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             cntrl,
  output logic             right_in,
  output logic             left_in,
  output logic             busy,
  output logic             done,
  output logic [7:0]       word_cnt
);

  localparam int c_CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_shadow, w_shadow_nxt;
  logic [c_CW-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic              r_cntrl, w_cntrl_nxt;
  logic              r_right, w_right_nxt;
  logic              r_left, w_left_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [7:0]        r_wcnt, w_wcnt_nxt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_bitcnt <= '0;
      r_cntrl  <= 1'b0;
      r_right  <= 1'b0;
      r_left   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wcnt   <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_cntrl  <= w_cntrl_nxt;
      r_right  <= w_right_nxt;
      r_left   <= w_left_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  // The shadow shifts toward the bit that goes out next, so the
  // following serial bit always sits at a fixed position.
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_bitcnt_nxt = r_bitcnt;
    w_cntrl_nxt  = r_cntrl;
    w_right_nxt  = 1'b0;
    w_left_nxt   = 1'b0;
    w_ready_nxt  = r_ready;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_wcnt_nxt   = r_wcnt;
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (in_valid && r_ready) begin
          w_state_nxt  = S_SHIFT;
          w_shadow_nxt = in_data;
          w_bitcnt_nxt = '0;
          w_cntrl_nxt  = in_dir;
          w_ready_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
          if (in_dir) w_left_nxt  = in_data[WIDTH-1];
          else        w_right_nxt = in_data[0];
        end
      end
      S_SHIFT: begin
        if (r_bitcnt == c_LAST) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_wcnt_nxt  = r_wcnt + 8'd1;
        end else begin
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_cntrl) begin
            w_shadow_nxt = r_shadow << 1;
            w_left_nxt   = r_shadow[WIDTH-2];
          end else begin
            w_shadow_nxt = r_shadow >> 1;
            w_right_nxt  = r_shadow[1];
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  assign in_ready = r_ready;
  assign cntrl    = r_cntrl;
  assign right_in = r_right;
  assign left_in  = r_left;
  assign busy     = r_busy;
  assign done     = r_done;
  assign word_cnt = r_wcnt;

endmodule
`default_nettype wire

// File: tb/tb_usr_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_usr_feeder: drives usr_feeder with directed and random words  |
// | and checks the serial stream against an attached usr model.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_usr_feeder;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_dir = 1'b0;
  logic             cntrl, right_in, left_in, busy, done;
  logic [7:0]       word_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  logic [WIDTH-1:0] usr_q = '0;

  usr_feeder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .cntrl(cntrl),
    .right_in(right_in), .left_in(left_in), .busy(busy),
    .done(done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream usr stage, as documented for its cntrl encoding.
  always @(posedge clk) begin
    if (cntrl == 1'b0) usr_q <= {right_in, usr_q[WIDTH-1:1]};
    else               usr_q <= {usr_q[WIDTH-2:0], left_in};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cntrl", 32'(cntrl), 32'd0);
    chk("rst_serial", {30'd0, right_in, left_in}, 32'd0);
    chk("rst_wcnt", 32'(word_cnt), 32'd0);
  endtask

  // Sends one word; expected serial bit k is data[k] (dir=0) or
  // data[WIDTH-1-k] (dir=1). Leaves in_valid high when hold is set.
  task automatic send_word(input logic [WIDTH-1:0] data, input logic dir, input bit hold);
    int tmo;
    logic exp_bit;
    in_valid = 1'b1;
    in_data  = data;
    in_dir   = dir;
    tmo = 0;
    while (!in_ready && tmo < 20) begin
      step();
      tmo++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    step();
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    if (!hold) in_valid = 1'b0;
    in_data = ~data;
    in_dir  = ~dir;
    for (int k = 0; k < WIDTH; k++) begin
      exp_bit = dir ? data[WIDTH-1-k] : data[k];
      chk("sh_right", 32'(right_in), dir ? 32'd0 : 32'(exp_bit));
      chk("sh_left", 32'(left_in), dir ? 32'(exp_bit) : 32'd0);
      chk("sh_cntrl", 32'(cntrl), 32'(dir));
      chk("sh_busy", 32'(busy), 32'd1);
      chk("sh_done", 32'(done), 32'd0);
      chk("sh_ready", 32'(in_ready), 32'd0);
      step();
    end
    exp_cnt = (exp_cnt + 1) % 256;
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_q", 32'(usr_q), 32'(data));
    chk("dn_wcnt", 32'(word_cnt), 32'(exp_cnt));
    chk("dn_serial", {30'd0, right_in, left_in}, 32'd0);
    chk("dn_busy", 32'(busy), 32'd1);
    step();
    chk("id_done", 32'(done), 32'd0);
    chk("id_busy", 32'(busy), 32'd0);
    chk("id_ready", 32'(in_ready), 32'd1);
    chk("id_cntrl", 32'(cntrl), 32'(dir));
    chk("id_serial", {30'd0, right_in, left_in}, 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             r;

    // Reset held with in_valid asserted
    clr = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hF;
    repeat (2) step();
    check_idle_reset();
    in_valid = 1'b0;
    clr = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Right load, then left load
    send_word(4'b1011, 1'b0, 1'b0);
    send_word(4'b1000, 1'b1, 1'b0);
    repeat (2) step();
    chk("cntrl_hold", 32'(cntrl), 32'd1);

    // Back-to-back with in_valid held
    send_word(4'h3, 1'b0, 1'b1);
    send_word(4'hC, 1'b1, 1'b1);
    in_valid = 1'b0;
    chk("b2b_spacing", 32'(acc_cyc - prev_acc), 32'(WIDTH + 2));
    chk("b2b_wcnt", 32'(word_cnt), 32'd4);

    // Abort after two bits have shifted
    d = 4'(($urandom));
    r = 1'($urandom);
    in_valid = 1'b1;
    in_data = d;
    in_dir = r;
    step();
    in_valid = 1'b0;
    step();
    step();
    clr = 1'b0;
    #1;
    check_idle_reset();
    step();
    check_idle_reset();
    clr = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    send_word(4'h5, 1'b0, 1'b0);
    chk("abort_wcnt", 32'(word_cnt), 32'd1);

    // Random words through the 255 -> 0 wrap
    for (int i = 0; i < 256; i++) begin
      d = 4'($urandom);
      r = 1'($urandom);
      send_word(d, r, ($urandom_range(0, 1) == 1));
      in_valid = 1'b0;
      if (exp_cnt == 255) chk("wrap_255", 32'(word_cnt), 32'd255);
      if (exp_cnt == 0)   chk("wrap_0", 32'(word_cnt), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
